// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared types and constants for the control unit. Contents:
//            - instruction word layout
//            - major opcodes
//            - ALU function codes (shared with the ALU)
//            - sequencer state encoding
//            - decoded control bundle
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam int INSTR_W = 24;

  // Instruction field bit positions
  localparam int MAJ_HI = 23;
  localparam int MAJ_LO = 20;
  localparam int FN_HI  = 19;
  localparam int FN_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;

  // Major opcodes; 8..E are undefined and execute as NOP with a sticky flag
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU_R = 4'h1;
  localparam logic [3:0] OP_ALU_I = 4'h2;
  localparam logic [3:0] OP_LDI   = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_BZ    = 4'h5;
  localparam logic [3:0] OP_BC    = 4'h6;
  localparam logic [3:0] OP_BNZ   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_PASS_A = 4'h7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_Z    = 3'd2,
    BR_C    = 3'd3,
    BR_NZ   = 3'd4
  } branch_t;

  typedef struct packed {
    logic       write_en;
    logic       write_alu;
    logic       imm_flag;
    logic [3:0] alu_opcode;
    logic [7:0] top_data;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    branch_t    branch;
    logic       is_alu;
    logic       is_illegal;
    logic       is_halt;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_if
// Purpose  : Bundles the instruction-ROM bus, datapath control/flag signals
//            and core status of the control unit.
// Ports    : master = control unit side (drives imem address/enable,
//            datapath controls, status); slave = memory/datapath/core side.
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
  parameter int PC_W = 8
) ();

  logic                        run;
  logic [PC_W-1:0]             imem_addr;
  logic                        imem_en;
  logic [ctrl_pkg::INSTR_W-1:0] imem_data;
  logic                        alu_zero;
  logic                        alu_carry;
  logic                        write_alu;
  logic [3:0]                  alu_opcode;
  logic [7:0]                  top_data;
  logic [3:0]                  write_addr;
  logic [3:0]                  ra_addr;
  logic [3:0]                  rb_addr;
  logic                        write_en;
  logic                        imm_flag;
  logic                        halted;
  logic                        illegal;
  logic                        instr_done;

  modport master (
    input  run, imem_data, alu_zero, alu_carry,
    output imem_addr, imem_en, write_alu, alu_opcode, top_data, write_addr,
           ra_addr, rb_addr, write_en, imm_flag, halted, illegal, instr_done
  );

  modport slave (
    output run, imem_data, alu_zero, alu_carry,
    input  imem_addr, imem_en, write_alu, alu_opcode, top_data, write_addr,
           ra_addr, rb_addr, write_en, imm_flag, halted, illegal, instr_done
  );

endinterface
`default_nettype wire

// File: rtl/control_unit_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode
// Purpose  : Purely combinational decode of the instruction register into
//            the control bundle. Not gated by sequencer state; the caller
//            qualifies the strobes with EXEC.
// Ports    : ir   (in)  instruction register
//            ctrl (out) decoded control bundle
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output ctrl_t              ctrl
);

  logic [3:0] w_major;
  logic [7:0] w_imm;

  assign w_major = ir[MAJ_HI:MAJ_LO];
  assign w_imm   = ir[IMM_HI:IMM_LO];

  always_comb begin
    ctrl = '0;
    // Register addresses always follow IR; the datapath ignores them
    // unless write_en is set.
    ctrl.write_addr = ir[RD_HI:RD_LO];
    ctrl.ra_addr    = ir[RA_HI:RA_LO];
    ctrl.rb_addr    = ir[RB_HI:RB_LO];
    case (w_major)
      OP_NOP: begin
      end
      OP_ALU_R: begin
        ctrl.write_en   = 1'b1;
        ctrl.write_alu  = 1'b1;
        ctrl.is_alu     = 1'b1;
        ctrl.alu_opcode = ir[FN_HI:FN_LO];
      end
      OP_ALU_I: begin
        ctrl.write_en   = 1'b1;
        ctrl.write_alu  = 1'b1;
        ctrl.imm_flag   = 1'b1;
        ctrl.is_alu     = 1'b1;
        ctrl.alu_opcode = ir[FN_HI:FN_LO];
        ctrl.top_data   = w_imm;
      end
      OP_LDI: begin
        ctrl.write_en = 1'b1;
        ctrl.top_data = w_imm;
      end
      OP_JMP:  ctrl.branch = BR_JMP;
      OP_BZ:   ctrl.branch = BR_Z;
      OP_BC:   ctrl.branch = BR_C;
      OP_BNZ:  ctrl.branch = BR_NZ;
      OP_HALT: ctrl.is_halt = 1'b1;
      default: ctrl.is_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Instruction sequencer for the 8-bit core. Operation:
//            - fetches from a synchronous ROM
//            - decodes via instr_decode
//            - latches ALU Z/C flags and resolves branches
//            - FETCH -> WAIT -> EXEC, 3 cycles per instruction
// Ports    : clk   (in) core clock
//            rst_n (in) synchronous active-low reset
//            bus   (control_unit_if.master) ROM bus, datapath controls,
//                  flags, run/halted/illegal/instr_done
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_z;
  logic                r_c;
  logic                r_illegal;
  ctrl_t               w_dec;
  logic                w_exec;
  logic                w_taken;
  logic [PC_W-1:0]     w_target;

  instr_decode u_decode (
    .ir   (r_ir),
    .ctrl (w_dec)
  );

  assign w_exec   = (r_state == ST_EXEC);
  assign w_target = r_ir[IMM_HI:IMM_LO];

  // Branches test the flags latched by the previous ALU instruction.
  always_comb begin
    w_taken = 1'b0;
    case (w_dec.branch)
      BR_JMP:  w_taken = 1'b1;
      BR_Z:    w_taken = r_z;
      BR_C:    w_taken = r_c;
      BR_NZ:   w_taken = ~r_z;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_FETCH: if (bus.run) w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_dec.is_halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = w_taken ? w_target : r_pc + PC_W'(1);
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == ST_WAIT) begin
        r_ir <= bus.imem_data;
      end
      if (w_exec && w_dec.is_alu) begin
        r_z <= bus.alu_zero;
        r_c <= bus.alu_carry;
      end
      if (w_exec && w_dec.is_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Enable is held off while in reset so the ROM sees no read in that cycle.
  assign bus.imem_addr  = r_pc;
  assign bus.imem_en    = rst_n && (r_state == ST_FETCH) && bus.run;

  assign bus.write_en   = w_exec & w_dec.write_en;
  assign bus.write_alu  = w_exec & w_dec.write_alu;
  assign bus.imm_flag   = w_exec & w_dec.imm_flag;
  assign bus.alu_opcode = w_exec ? w_dec.alu_opcode : 4'h0;
  assign bus.top_data   = w_exec ? w_dec.top_data : 8'h00;
  assign bus.write_addr = w_dec.write_addr;
  assign bus.ra_addr    = w_dec.ra_addr;
  assign bus.rb_addr    = w_dec.rb_addr;

  assign bus.halted     = (r_state == ST_HALT);
  assign bus.illegal    = r_illegal;
  assign bus.instr_done = w_exec;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit. Directed program in a
//            behavioural ROM; expected EXEC controls queued per instruction
//            and compared when instr_done is seen.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  typedef struct packed {
    logic       we;
    logic       walu;
    logic       immf;
    logic [3:0] op;
    logic [7:0] top;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] npc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [23:0] rom [256];
  exp_t        q_exp [$];
  int          n_vec;
  int          n_err;

  control_unit_if #(.PC_W(8)) bus ();

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM: data valid the cycle after the enable.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
  end

  function automatic exp_t mk(input logic we, input logic walu,
                              input logic immf, input logic [3:0] op,
                              input logic [7:0] top, input logic [3:0] wa,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [7:0] npc);
    exp_t e;
    e = '{we, walu, immf, op, top, wa, ra, rb, npc};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the EXEC cycle; returns at its falling edge.
  task automatic wait_exec(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.instr_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed no instr_done expected pulse within 8 cycles", tag);
    end
  endtask

  // One instruction: queue the expectation, present ALU flags, compare the
  // EXEC controls, then check the pulse ended and the next fetch address.
  task automatic step(input string tag, input exp_t e, input logic z,
                      input logic c);
    exp_t got;
    bit   ok;
    q_exp.push_back(e);
    bus.alu_zero  = z;
    bus.alu_carry = c;
    wait_exec(tag, ok);
    got = q_exp.pop_front();
    if (ok) begin
      chk({tag, ".write_en"},   bus.write_en,   got.we);
      chk({tag, ".write_alu"},  bus.write_alu,  got.walu);
      chk({tag, ".imm_flag"},   bus.imm_flag,   got.immf);
      chk({tag, ".alu_opcode"}, bus.alu_opcode, got.op);
      chk({tag, ".top_data"},   bus.top_data,   got.top);
      chk({tag, ".write_addr"}, bus.write_addr, got.wa);
      chk({tag, ".ra_addr"},    bus.ra_addr,    got.ra);
      chk({tag, ".rb_addr"},    bus.rb_addr,    got.rb);
      @(negedge clk);
      chk({tag, ".done_pulse"}, bus.instr_done, 1'b0);
      chk({tag, ".next_pc"},    bus.imem_addr,  got.npc);
    end
  endtask

  initial begin
    bit ok;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
    rom[8'h00] = 24'h301005;  // LDI r1, 05
    rom[8'h01] = 24'h2021FB;  // ALU_I r2 = r1 ADD FB
    rom[8'h02] = 24'h000000;  // NOP
    rom[8'h03] = 24'h500040;  // BZ 40
    rom[8'h40] = 24'h700010;  // BNZ 10
    rom[8'h41] = 24'h143102;  // ALU_R r3 = r1 XOR r2
    rom[8'h42] = 24'h600050;  // BC 50
    rom[8'h43] = 24'h700020;  // BNZ 20
    rom[8'h20] = 24'h4000FF;  // JMP FF
    rom[8'hFF] = 24'h000000;  // NOP -> wraps to 00

    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.alu_carry = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.run = 1'b1;
    #1;
    chk("rst.imem_en",    bus.imem_en,    1'b0);
    chk("rst.imem_addr",  bus.imem_addr,  8'h00);
    chk("rst.write_en",   bus.write_en,   1'b0);
    chk("rst.top_data",   bus.top_data,   8'h00);
    chk("rst.halted",     bus.halted,     1'b0);
    chk("rst.illegal",    bus.illegal,    1'b0);
    chk("rst.instr_done", bus.instr_done, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("fetch0.imem_en", bus.imem_en, 1'b1);

    step("ldi",     mk(1, 0, 0, 4'h0, 8'h05, 4'h1, 4'h0, 4'h5, 8'h01), 1'b0, 1'b0);
    step("alui",    mk(1, 1, 1, 4'h0, 8'hFB, 4'h2, 4'h1, 4'hB, 8'h02), 1'b1, 1'b1);
    step("nop",     mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h03), 1'b0, 1'b0);
    step("bz_tk",   mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h40), 1'b0, 1'b0);
    step("bnz_nt",  mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h41), 1'b0, 1'b0);
    step("alur",    mk(1, 1, 0, 4'h4, 8'h00, 4'h3, 4'h1, 4'h2, 8'h42), 1'b0, 1'b0);
    step("bc_nt",   mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h43), 1'b0, 1'b0);
    step("bnz_tk",  mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h20), 1'b0, 1'b0);
    step("jmp",     mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'hF, 8'hFF), 1'b0, 1'b0);
    step("nop_wrap", mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00), 1'b0, 1'b0);

    // Hold in FETCH with run low.
    bus.run = 1'b0;
    rom[8'h03] = 24'hF00000;  // HALT replaces the BZ for the second pass
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause.imem_en",    bus.imem_en,    1'b0);
      chk("pause.imem_addr",  bus.imem_addr,  8'h00);
      chk("pause.instr_done", bus.instr_done, 1'b0);
    end
    bus.run = 1'b1;
    #1;
    chk("resume.imem_en",   bus.imem_en,   1'b1);
    chk("resume.imem_addr", bus.imem_addr, 8'h00);

    step("ldi2",  mk(1, 0, 0, 4'h0, 8'h05, 4'h1, 4'h0, 4'h5, 8'h01), 1'b0, 1'b0);
    step("alui2", mk(1, 1, 1, 4'h0, 8'hFB, 4'h2, 4'h1, 4'hB, 8'h02), 1'b1, 1'b1);
    step("nop2",  mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h03), 1'b0, 1'b0);
    step("halt",  mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h03), 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      chk("halt.halted",     bus.halted,     1'b1);
      chk("halt.imem_en",    bus.imem_en,    1'b0);
      chk("halt.imem_addr",  bus.imem_addr,  8'h03);
      chk("halt.instr_done", bus.instr_done, 1'b0);
      @(negedge clk);
    end

    // Leave HALT through reset; next program: illegal, then ALU_R cut by reset.
    rom[8'h00] = 24'hA00000;
    rom[8'h01] = 24'h114123;
    rst_n = 1'b0;
    @(negedge clk);
    chk("hrst.halted",    bus.halted,    1'b0);
    chk("hrst.imem_addr", bus.imem_addr, 8'h00);
    chk("hrst.imem_en",   bus.imem_en,   1'b0);
    rst_n = 1'b1;

    step("illegal", mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h01), 1'b0, 1'b0);
    chk("illegal.sticky", bus.illegal, 1'b1);

    bus.alu_zero  = 1'b1;
    bus.alu_carry = 1'b1;
    wait_exec("alur_rst", ok);
    if (ok) begin
      chk("alur_rst.write_en",   bus.write_en,   1'b1);
      chk("alur_rst.alu_opcode", bus.alu_opcode, 4'h1);
      chk("alur_rst.illegal",    bus.illegal,    1'b1);
      rom[8'h00] = 24'h500080;  // BZ 80: taken only if Z leaked through reset
      rst_n = 1'b0;
      @(negedge clk);
      chk("alur_rst.imem_addr", bus.imem_addr, 8'h00);
      chk("alur_rst.illegal0",  bus.illegal,   1'b0);
      chk("alur_rst.halted",    bus.halted,    1'b0);
      rst_n = 1'b1;
      #1;
      chk("alur_rst.fetch", bus.imem_en, 1'b1);
      step("bz_after_rst", mk(0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h01), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
